// File: rtl/mul_sequencer.sv
// Multi-cycle 32x32->64 multiplier: radix-2 Booth when signed, shift-add when unsigned.
// Latency 32 clocks from accepted start to done; start_i is ignored while busy_o is high.
module mul_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] mcand_i,
    input  logic [31:0] mplier_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] high_o,
    output logic [31:0] low_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [32:0] r_acc;
    logic [31:0] r_lo;
    logic [31:0] r_mc;
    logic        r_qm1;
    logic        r_sgn;
    logic [5:0]  r_cnt;
    logic [31:0] r_high;
    logic [31:0] r_low;

    logic        w_accept;
    logic        w_last;
    logic [32:0] w_mc33;
    logic [32:0] w_sum;
    logic [32:0] w_acc_nxt;
    logic [31:0] w_lo_nxt;

    assign w_accept = start_i && (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_cnt == 6'd31);

    // One multiply step: add/sub modulo 2^33, then shift {acc, lo} right by one.
    always_comb begin
        w_mc33 = r_sgn ? {r_mc[31], r_mc} : {1'b0, r_mc};
        w_sum  = r_acc;
        if (r_sgn) begin
            case ({r_lo[0], r_qm1})
                2'b01:   w_sum = r_acc + w_mc33;
                2'b10:   w_sum = r_acc - w_mc33;
                default: w_sum = r_acc;
            endcase
        end else if (r_lo[0]) begin
            w_sum = r_acc + w_mc33;
        end
        w_acc_nxt = {r_sgn & w_sum[32], w_sum[32:1]};
        w_lo_nxt  = {w_sum[0], r_lo[31:1]};
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_next = S_RUN;
            S_RUN:   if (r_cnt == 6'd31) w_next = S_DONE;
            S_DONE:  w_next = start_i ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= 33'd0;
            r_lo   <= 32'd0;
            r_mc   <= 32'd0;
            r_qm1  <= 1'b0;
            r_sgn  <= 1'b0;
            r_cnt  <= 6'd0;
            r_high <= 32'd0;
            r_low  <= 32'd0;
        end else if (w_accept) begin
            r_acc  <= 33'd0;
            r_lo   <= mplier_i;
            r_mc   <= mcand_i;
            r_qm1  <= 1'b0;
            r_sgn  <= signed_i;
            r_cnt  <= 6'd0;
        end else if (r_state == S_RUN) begin
            r_acc  <= w_acc_nxt;
            r_lo   <= w_lo_nxt;
            r_qm1  <= r_sgn & r_lo[0];
            r_cnt  <= r_cnt + 6'd1;
            // Product words only move on the final step, so they hold across later runs.
            if (w_last) begin
                r_high <= w_acc_nxt[31:0];
                r_low  <= w_lo_nxt;
            end
        end
    end

    assign busy_o = (r_state == S_RUN);
    assign done_o = (r_state == S_DONE);
    assign high_o = r_high;
    assign low_o  = r_low;

endmodule
